interrupt_controller: RTL and testbench

//   Responder side of the CPU interrupt handshake. Latches requests from I/O

---
 rtl/interrupt_controller.sv | 117 +++++++++++
 tb/tb_interrupt_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: edge-latched requests plus a user-mode quantum timer,
// handshaking with the control unit through intr / inta / clearIntr.
module interrupt_controller #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned QUANTUM = 1000,
    parameter int unsigned TIMER_W = 16
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               timer_en,
    input  logic               inta,
    input  logic               clearIntr,
    output logic               intr,
    output logic [31:0]        intCode,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {StIdle, StRequest, StService} state_e;

    state_e               state_q, state_d;
    logic                 intr_q, intr_d;
    logic [31:0]          code_q, code_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [NUM_SRC-1:0]   armed_q, armed_d;
    logic [TIMER_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   clr_mask;
    logic [NUM_SRC-1:0]   timer_mask;
    logic [31:0]          win_code;

    // armed_q holds the inverted previous input; clearing it at reset makes a line that is
    // already high when reset releases look like it has not risen.
    always_comb begin
        armed_d = ~irq_src;
        rise    = irq_src & armed_q;
        rise[0] = 1'b0;
    end

    always_comb begin
        cnt_d      = '0;
        timer_mask = '0;
        if (timer_en) begin
            if (cnt_q == TIMER_W'(QUANTUM - 1)) begin
                timer_mask[0] = 1'b1;
            end else begin
                cnt_d = cnt_q + TIMER_W'(1);
            end
        end
    end

    always_comb begin
        win_code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) win_code = 32'(i + 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        intr_d   = intr_q;
        code_d   = code_q;
        clr_mask = '0;
        unique case (state_q)
            StIdle: begin
                intr_d = 1'b0;
                code_d = '0;
                if (pend_q != '0) begin
                    code_d  = win_code;
                    intr_d  = 1'b1;
                    state_d = StRequest;
                end
            end
            StRequest: begin
                if (inta) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (code_q == 32'(i + 1)) clr_mask[i] = 1'b1;
                    end
                    intr_d  = 1'b0;
                    state_d = StService;
                end
            end
            StService: begin
                if (clearIntr) begin
                    code_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // New edges are ORed in after the acknowledge clear so a set always wins.
        pend_d = (pend_q & ~clr_mask) | rise | timer_mask;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            intr_q  <= 1'b0;
            code_q  <= '0;
            pend_q  <= '0;
            armed_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign intr    = intr_q;
    assign intCode = code_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: scoreboard of expected grant codes plus
// per-scenario inline checks of pending/intr/intCode timing.
module tb_interrupt_controller;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq_src = 4'b0;
    logic        timer_en = 1'b0;
    logic        inta = 1'b0;
    logic        clearIntr = 1'b0;
    logic        intr;
    logic [31:0] intCode;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    interrupt_controller #(
        .NUM_SRC(4),
        .QUANTUM(8),
        .TIMER_W(4)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .irq_src  (irq_src),
        .timer_en (timer_en),
        .inta     (inta),
        .clearIntr(clearIntr),
        .intr     (intr),
        .intCode  (intCode),
        .pending  (pending)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        irq_src = 4'b0110;
        tick();
        tick();
        checks++;
        if (intr !== 1'b0 || intCode !== 32'd0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold: intr=%b intCode=%0d pending=%b want 0/0/0000",
                     intr, intCode, pending);
        end
        rst = 1'b1;
        repeat (4) tick();
        checks++;
        if (intr !== 1'b0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: intr=%b pending=%b want 0/0000", intr, pending);
        end
    endtask

    task automatic test_single();
        int e;
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100;
        exp_q.push_back(3);
        tick();
        checks++;
        if (pending !== 4'b0100 || intr !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pending=%b intr=%b want 0100/0", pending, intr);
        end
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL single_grant: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        tick();
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        checks++;
        if (intr !== 1'b0 || pending !== 4'b0 || intCode !== 32'd3) begin
            errors++;
            $display("FAIL single_ack: intr=%b pending=%b intCode=%0d want 0/0000/3",
                     intr, pending, intCode);
        end
        tick();
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        checks++;
        if (intCode !== 32'd0) begin
            errors++;
            $display("FAIL single_clear: intCode=%0d want 0", intCode);
        end
    endtask

    task automatic test_priority();
        int e;
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b1010;
        exp_q.push_back(2);
        exp_q.push_back(4);
        tick();
        checks++;
        if (pending !== 4'b1010) begin
            errors++;
            $display("FAIL prio_pend: pending=%b want 1010", pending);
        end
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL prio_first: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        checks++;
        if (pending !== 4'b1000) begin
            errors++;
            $display("FAIL prio_ack: pending=%b want 1000", pending);
        end
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        checks++;
        if (intr !== 1'b0 || intCode !== 32'd0) begin
            errors++;
            $display("FAIL prio_idle: intr=%b intCode=%0d want 0/0", intr, intCode);
        end
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL prio_second: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        irq_src = 4'b0000;
    endtask

    task automatic test_timer();
        int e;
        timer_en = 1'b1;
        repeat (7) tick();
        checks++;
        if (pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL timer_early: pending[0]=%b want 0", pending[0]);
        end
        tick();
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL timer_fire: pending[0]=%b want 1", pending[0]);
        end
        timer_en = 1'b0;
        exp_q.push_back(1);
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL timer_grant: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        // Partial quantum, pause, then a full quantum from zero.
        timer_en = 1'b1;
        repeat (5) tick();
        timer_en = 1'b0;
        tick();
        timer_en = 1'b1;
        repeat (7) tick();
        checks++;
        if (pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL timer_restart_early: pending[0]=%b want 0", pending[0]);
        end
        tick();
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL timer_restart_fire: pending[0]=%b want 1", pending[0]);
        end
        timer_en = 1'b0;
        exp_q.push_back(1);
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL timer_regrant: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e;
        irq_src = 4'b0010;
        exp_q.push_back(2);
        tick();
        irq_src = 4'b0000;
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL b2b_first: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        irq_src = 4'b0010;
        inta = 1'b1;
        exp_q.push_back(2);
        tick();
        inta = 1'b0;
        checks++;
        if (pending !== 4'b0010 || intr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_set_wins: pending=%b intr=%b want 0010/0", pending, intr);
        end
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        checks++;
        if (intCode !== 32'd0) begin
            errors++;
            $display("FAIL b2b_clear: intCode=%0d want 0", intCode);
        end
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL b2b_again: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        clearIntr = 1'b1;
        tick();
        clearIntr = 1'b0;
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_drained: pending=%b want 0000", pending);
        end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        int e;
        irq_src = 4'b0100;
        exp_q.push_back(3);
        tick();
        tick();
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (intr !== 1'b1 || intCode !== 32'(e)) begin
            errors++;
            $display("FAIL mid_grant: intr=%b intCode=%0d want 1/%0d", intr, intCode, e);
        end
        irq_src = 4'b1100;
        inta = 1'b1;
        tick();
        inta = 1'b0;
        checks++;
        if (pending !== 4'b1000 || intr !== 1'b0 || intCode !== 32'd3) begin
            errors++;
            $display("FAIL mid_service: pending=%b intr=%b intCode=%0d want 1000/0/3",
                     pending, intr, intCode);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b0 || intCode !== 32'd0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: intr=%b intCode=%0d pending=%b want 0/0/0000",
                     intr, intCode, pending);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (intr !== 1'b0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL mid_after: intr=%b pending=%b want 0/0000", intr, pending);
        end
        irq_src = 4'b0000;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_timer();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
